// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - TCDM arbiter shared widths, request field offsets and request layout
package tcdm_arb_pkg;

  localparam int TCDM_REQ_W  = 57;
  localparam int TCDM_DATA_W = 32;

  localparam int ADDR_LSB  = 37;
  localparam int BE_LSB    = 33;
  localparam int WDATA_LSB = 1;
  localparam int WEN_BIT   = 0;

  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wen;
  } tcdm_req_t;

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// rtl/tcdm_arb_id_fifo.sv - in-order master-ID FIFO; pointers carry one extra wrap bit
module tcdm_arb_id_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic            full,
  output logic            empty,
  output logic [PW-1:0]   count
);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_id;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // ID storage needs no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tcdm_arbiter.sv
// rtl/tcdm_arbiter.sv - round-robin share of one TCDM bridge port with in-order response steering
// TCDM_ARB_FIXED_PRIO_EN: pin the search start to 0 so the lowest index always wins.
module tcdm_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int REQ_W           = TCDM_REQ_W,
  parameter int DATA_W          = TCDM_DATA_W,
  localparam int ID_W  = $clog2(NUM_PORTS),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       efpga_clk,
  input  logic                       efpga_rst_n,
  input  logic [NUM_PORTS-1:0]       m_req,
  output logic [NUM_PORTS-1:0]       m_gnt,
  input  logic [NUM_PORTS*REQ_W-1:0] m_req_data,
  output logic [NUM_PORTS-1:0]       m_valid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       s_req,
  input  logic                       s_gnt,
  output logic [REQ_W-1:0]           s_req_data,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic [CNT_W-1:0]           outstanding
);

  localparam logic [ID_W:0] NP = (ID_W + 1)'(NUM_PORTS);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  idx;
  logic             any_req;
  logic             id_full, id_empty;
  logic [ID_W-1:0]  id_head;
  logic             accept, pop;
  logic [REQ_W-1:0] req_slice [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_slice[i] = m_req_data[i*REQ_W +: REQ_W];
    end
  end

  // Search upward from rr_ptr with wrap; first hit wins
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (sum >= NP) sum = sum - NP;
      idx = sum[ID_W-1:0];
      if (!any_req && m_req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign s_req_data = any_req ? req_slice[winner] : '0;
  assign s_req      = any_req & ~id_full & efpga_rst_n;
  assign accept     = s_req & s_gnt;
  assign pop        = s_valid & ~id_empty & efpga_rst_n;
  assign m_rdata    = s_rdata;

  always_comb begin
    m_gnt   = '0;
    m_valid = '0;
    if (accept) m_gnt[winner]  = 1'b1;
    if (pop)    m_valid[id_head] = 1'b1;
  end

`ifdef TCDM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (winner == ID_W'(NUM_PORTS - 1)) ? '0 : winner + ID_W'(1);
    end
  end

  always_ff @(posedge efpga_clk) begin
    if (!efpga_rst_n) rr_ptr_q <= '0;
    else              rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  tcdm_arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (efpga_clk),
    .rst_n   (efpga_rst_n),
    .push    (accept),
    .push_id (winner),
    .pop     (pop),
    .head    (id_head),
    .full    (id_full),
    .empty   (id_empty),
    .count   (outstanding)
  );

endmodule

// File: tb/tb_tcdm_arbiter.sv
// tb/tb_tcdm_arbiter.sv - vector table plus response-ID scoreboard for tcdm_arbiter
module tb_tcdm_arbiter;
  import tcdm_arb_pkg::*;

  localparam int NP = 4;
  localparam int MO = 8;
  localparam int RW = TCDM_REQ_W;
  localparam int DW = TCDM_DATA_W;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            efpga_rst_n;
  logic [NP-1:0]   m_req;
  logic [NP-1:0]   m_gnt;
  logic [NP*RW-1:0] m_req_data;
  logic [NP-1:0]   m_valid;
  logic [DW-1:0]   m_rdata;
  logic            s_req;
  logic            s_gnt;
  logic [RW-1:0]   s_req_data;
  logic            s_valid;
  logic [DW-1:0]   s_rdata;
  logic [CW-1:0]   outstanding;

  always #5 clk = ~clk;

  tcdm_arbiter #(
    .NUM_PORTS       (NP),
    .MAX_OUTSTANDING (MO),
    .REQ_W           (RW),
    .DATA_W          (DW)
  ) dut (
    .efpga_clk   (clk),
    .efpga_rst_n (efpga_rst_n),
    .m_req       (m_req),
    .m_gnt       (m_gnt),
    .m_req_data  (m_req_data),
    .m_valid     (m_valid),
    .m_rdata     (m_rdata),
    .s_req       (s_req),
    .s_gnt       (s_gnt),
    .s_req_data  (s_req_data),
    .s_valid     (s_valid),
    .s_rdata     (s_rdata),
    .outstanding (outstanding)
  );

  typedef struct {
    logic          rst_n;
    logic [NP-1:0] req;
    logic          gnt;
    logic          valid;
    logic [DW-1:0] rdata;
    logic          exp_sreq;
    int            exp_win;
    int            exp_out;
  } vec_t;

  vec_t          tbl[$];
  int            sb[$];
  logic [RW-1:0] payload [NP];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic add(input logic rst_n, input logic [NP-1:0] req, input logic gnt,
                     input logic valid, input logic [DW-1:0] rdata,
                     input logic exp_sreq, input int exp_win, input int exp_out);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.gnt = gnt; v.valid = valid; v.rdata = rdata;
    v.exp_sreq = exp_sreq; v.exp_win = exp_win; v.exp_out = exp_out;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    logic [NP-1:0] eg;
    logic [NP-1:0] ev;
    logic [RW-1:0] ed;
    int            id;
    efpga_rst_n = v.rst_n;
    m_req       = v.req;
    s_gnt       = v.gnt;
    s_valid     = v.valid;
    s_rdata     = v.rdata;
    @(negedge clk);
    eg = '0;
    ev = '0;
    ed = '0;
    if (v.exp_win >= 0) ed = payload[v.exp_win];
    if (v.exp_sreq && v.gnt) eg[v.exp_win] = 1'b1;
    if (!v.rst_n) sb.delete();
    else if (v.valid && sb.size() > 0) begin
      id = sb.pop_front();
      ev[id] = 1'b1;
    end
    check($sformatf("v%0d m_gnt", n), 64'(m_gnt), 64'(eg));
    check($sformatf("v%0d s_req", n), 64'(s_req), 64'(v.exp_sreq));
    check($sformatf("v%0d s_req_data", n), 64'(s_req_data), 64'(ed));
    check($sformatf("v%0d m_valid", n), 64'(m_valid), 64'(ev));
    check($sformatf("v%0d m_rdata", n), 64'(m_rdata), 64'(v.rdata));
    check($sformatf("v%0d outstanding", n), 64'(outstanding), 64'(v.exp_out));
    if (eg != '0) sb.push_back(v.exp_win);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tcdm_req_t r;
    for (int i = 0; i < NP; i++) begin
      r.addr  = 20'(32'hA0000 + i * 16);
      r.be    = 4'(i + 1);
      r.wdata = 32'hC0DE_0000 + 32'(i);
      r.wen   = i[0];
      payload[i] = r;
      m_req_data[i*RW +: RW] = r;
    end

    // Reset holds everything quiet even with requests and responses present
    for (int k = 0; k < 3; k++) add(0, 4'hF, 1, 1, 32'h5, 0, 0, 0);

`ifdef TCDM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 8; k++) add(1, 4'b0011, 1, 0, 32'h0, 1, 0, k);
    for (int k = 0; k < 2; k++) add(1, 4'b0011, 1, 0, 32'h0, 0, 0, 8);
    for (int k = 0; k < 8; k++) add(1, 4'b0000, 0, 1, 32'h200 + 32'(k), 0, -1, 8 - k);
    add(1, 4'b0000, 0, 0, 32'h0, 0, -1, 0);
`else
    // Round-robin fill to full, then full stall even when a response pops
    for (int k = 0; k < 8; k++) add(1, 4'hF, 1, 0, 32'h0, 1, k % 4, k);
    for (int k = 0; k < 2; k++) add(1, 4'hF, 1, 0, 32'h0, 0, 0, 8);
    add(1, 4'hF, 1, 1, 32'h77, 0, 0, 8);
    for (int k = 0; k < 7; k++) add(1, 4'h0, 0, 1, 32'h100 + 32'(k), 0, -1, 7 - k);
    add(1, 4'h0, 0, 1, 32'h1FF, 0, -1, 0);
    add(1, 4'h0, 0, 0, 32'h0, 0, -1, 0);

    // Routing: accept 2, 0, 3 then responses A, B, C
    add(1, 4'b0100, 1, 0, 32'h0, 1, 2, 0);
    add(1, 4'b0001, 1, 0, 32'h0, 1, 0, 1);
    add(1, 4'b1000, 1, 0, 32'h0, 1, 3, 2);
    add(1, 4'b0000, 0, 1, 32'hA, 0, -1, 3);
    add(1, 4'b0000, 0, 1, 32'hB, 0, -1, 2);
    add(1, 4'b0000, 0, 1, 32'hC, 0, -1, 1);
    add(1, 4'b0000, 0, 0, 32'h0, 0, -1, 0);

    // Backpressure on master 1, then release
    for (int k = 0; k < 5; k++) add(1, 4'b0010, 0, 0, 32'h0, 1, 1, 0);
    add(1, 4'b0010, 1, 0, 32'h0, 1, 1, 0);

    // Simultaneous push and pop at outstanding 3
    add(1, 4'hF, 1, 0, 32'h0, 1, 2, 1);
    add(1, 4'hF, 1, 0, 32'h0, 1, 3, 2);
    add(1, 4'hF, 1, 1, 32'h55, 1, 0, 3);
    add(1, 4'h0, 0, 0, 32'h0, 0, -1, 3);
    for (int k = 0; k < 3; k++) add(1, 4'h0, 0, 1, 32'h300 + 32'(k), 0, -1, 3 - k);
    add(1, 4'h0, 0, 0, 32'h0, 0, -1, 0);

    // Reset mid-operation discards tracking; later response is stray
    add(1, 4'b0110, 1, 0, 32'h0, 1, 1, 0);
    add(1, 4'b0110, 1, 0, 32'h0, 1, 2, 1);
    add(0, 4'b0000, 1, 1, 32'hBAD, 0, -1, 2);
    add(1, 4'b0000, 1, 1, 32'hBAD2, 0, -1, 0);
    add(1, 4'b0000, 0, 0, 32'h0, 0, -1, 0);
    add(1, 4'b1010, 1, 0, 32'h0, 1, 1, 0);
    add(1, 4'b0000, 0, 1, 32'h3, 0, -1, 1);
    add(1, 4'b0000, 0, 0, 32'h0, 0, -1, 0);
`endif

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_arbiter.md
Name: tcdm_arbiter

Overview:
- Shares one eFPGA-side TCDM bridge port between NUM_PORTS eFPGA fabric masters.
- Sits in the eFPGA clock domain, upstream of the async request/response bridge; its s_* side connects directly to the bridge's efpga_* side.
- Round-robin arbitration of requests.
- In-order ID tracking so every bridge response is steered back to the master that issued it.

Parameters:
- NUM_PORTS, 4, number of requesting masters (2..8).
- MAX_OUTSTANDING, 8, max accepted-but-unanswered transactions; power of 2.
- REQ_W, 57, request payload width: addr20 + be4 + wdata32 + wen1.
- DATA_W, 32, response data width.

Ports:
- efpga_clk  in  1  eFPGA domain clock.
- efpga_rst_n  in  1  synchronous active-low reset.
- m_req  in  NUM_PORTS  per-master request, level.
- m_gnt  out  NUM_PORTS  per-master grant; one-hot or zero.
- m_req_data  in  NUM_PORTS*REQ_W  per-master payload; master i at slice [i*REQ_W +: REQ_W].
- m_valid  out  NUM_PORTS  per-master response strobe; one-hot or zero.
- m_rdata  out  DATA_W  shared response data, valid with m_valid.
- s_req  out  1  request to bridge.
- s_gnt  in  1  bridge grant (level, = bridge not full).
- s_req_data  out  REQ_W  muxed winner payload.
- s_valid  in  1  bridge response valid; consumed the same cycle it is high.
- s_rdata  in  DATA_W  bridge response data.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

Behaviour:
- Clock and reset: one clock, efpga_clk. efpga_rst_n is synchronous, active-low.
- Reset values:
  - rr_ptr=0, ID FIFO empty, outstanding=0.
  - While efpga_rst_n=0: m_gnt=0, m_valid=0, s_req=0.
- Arbitration (combinational):
  - Winner = first asserted m_req at or after rr_ptr, searching upward with wrap.
  - s_req = (|m_req) & !id_full & efpga_rst_n.
  - s_req_data = winner's slice, or 0 when no request.
  - m_gnt[winner] = s_req & s_gnt.
- Accept:
  - A transaction is accepted when s_req & s_gnt.
  - On accept, next cycle: rr_ptr = (winner+1) mod NUM_PORTS, and winner index is pushed to the ID FIFO.
  - No accept: rr_ptr holds.
- Every transaction, read or write, produces exactly one response, in order.
- Response path, zero added latency:
  - When s_valid=1 and ID FIFO not empty: m_valid[id_head]=1, m_rdata=s_rdata, ID FIFO pops.
  - m_rdata = s_rdata at all times (no gating).
- Stray s_valid with ID FIFO empty: dropped; no m_valid; counters unchanged.
- Full condition: when outstanding == MAX_OUTSTANDING, s_req=0 and no grants. Applies even if a pop occurs that cycle (conservative; no push-when-full bypass).
- Simultaneous accept and response (not full): push and pop in the same cycle; outstanding unchanged.
- outstanding: +1 on accept-only, -1 on pop-only, registered.
- Masters must hold m_req and m_req_data stable until m_gnt; the arbiter does not check this.
- Reset mid-operation:
  - All tracking is discarded.
  - Responses arriving after reset release are treated as stray and dropped.
  - The bridge is reset by the same system event.
- ID FIFO pointers: $clog2(MAX_OUTSTANDING)+1 bits, wrap naturally; full/empty from MSB compare.

Optional Feature:
- Macro: TCDM_ARB_FIXED_PRIO_EN.
- Defined: rr_ptr removed and pinned to 0; lowest index wins always. Starvation of high indices is permitted.
- Undefined: round-robin as above.
- Ports are identical in both builds.

Decomposition:
- Package tcdm_arb_pkg:
  - TCDM_REQ_W=57, TCDM_DATA_W=32.
  - Field offsets: ADDR_LSB=37, BE_LSB=33, WDATA_LSB=1, WEN_BIT=0.
  - typedef tcdm_req_t: packed struct {addr[19:0], be[3:0], wdata[31:0], wen}.
- Sub-module tcdm_arb_id_fifo:
  - Synchronous FIFO of $clog2(NUM_PORTS)-bit IDs, depth MAX_OUTSTANDING.
  - push/pop/full/empty/head/count; same clock and reset.

Test Plan:
- Reset: hold efpga_rst_n=0 with m_req=4'b1111, s_gnt=1 -> m_gnt=0, s_req=0, m_valid=0, outstanding=0.
- Round-robin: m_req=4'b1111, s_gnt=1, no responses -> grants in order 0,1,2,3,0,1,2,3 one per cycle. At outstanding=8, s_req drops to 0.
- Routing: accept from masters 2,0,3, then s_valid for 3 cycles with s_rdata=0xA,0xB,0xC -> m_valid[2] with 0xA, m_valid[0] with 0xB, m_valid[3] with 0xC.
- Backpressure: s_gnt=0 for 5 cycles with m_req[1]=1 -> m_gnt=0, payload on s_req_data stable, rr_ptr unchanged. s_gnt=1 -> m_gnt[1] next cycle.
- Simultaneous push/pop at outstanding=3 -> outstanding stays 3. Stray s_valid at outstanding=0 -> m_valid=0.
- With TCDM_ARB_FIXED_PRIO_EN: m_req=4'b0011 held, s_gnt=1 -> master 0 granted every cycle until the full stall, master 1 never.
